// File: rtl/uart_pkg.sv
// uart_pkg: shared data width and arbiter state encoding.
package uart_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, START, WAIT} state_e;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester, uart_tx and status signals of the two-requester arbiter.
interface uart_tx_arbiter_if;
  import uart_pkg::*;
  logic              req0;
  logic [DATA_W-1:0] data0;
  logic              ack0;
  logic              req1;
  logic [DATA_W-1:0] data1;
  logic              ack1;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_finish;
  logic              busy;
  logic              grant_id;
  logic              timeout_err;
  logic              err_clr;
  modport master (
    output req0, data0, req1, data1, tx_finish, err_clr,
    input  ack0, ack1, tx_start, tx_data, busy, grant_id, timeout_err
  );
  modport slave (
    input  req0, data0, req1, data1, tx_finish, err_clr,
    output ack0, ack1, tx_start, tx_data, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding one uart_tx from two byte requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              grant_q, grant_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              win, timeout;
  always_comb begin
    win     = (bus.req0 && bus.req1) ? ~grant_q : bus.req1;
    timeout = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    cnt_d   = '0;
    err_d   = err_q & ~bus.err_clr;
    case (state_q)
      IDLE: if (bus.req0 || bus.req1) begin
        state_d = START;
        data_d  = win ? bus.data1 : bus.data0;
        grant_d = win;
      end
      START: state_d = WAIT;
      WAIT: begin
        // a finish arriving on the last allowed cycle beats the timeout
        if (bus.tx_finish) state_d = IDLE;
        else if (timeout) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      grant_q <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.tx_start    = state_q == START;
  assign bus.ack0        = state_q == START && !grant_q;
  assign bus.ack1        = state_q == START && grant_q;
  assign bus.tx_data     = data_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.grant_id    = grant_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks on a default-timeout and a 16-cycle-timeout arbiter sharing one stimulus.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int ba, bb, sa, k0, k1;
  uart_tx_arbiter_if ia ();
  uart_tx_arbiter_if ib ();
  uart_tx_arbiter dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  assign ib.req0      = ia.req0;
  assign ib.data0     = ia.data0;
  assign ib.req1      = ia.req1;
  assign ib.data1     = ia.data1;
  assign ib.tx_finish = ia.tx_finish;
  assign ib.err_clr   = ia.err_clr;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // one req0 request, then 30 observed cycles; finish/clear fire in cycle fin/clr (cycle 1 = START)
  task automatic frame(input logic [7:0] d, input int fin, input int clr);
    ba = 0; bb = 0; sa = 0; k0 = 0; k1 = 0;
    ia.data0 = d;
    ia.req0  = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 30; i++) begin
      ba += int'(ia.busy);
      bb += int'(ib.busy);
      sa += int'(ia.tx_start);
      k0 += int'(ia.ack0);
      k1 += int'(ia.ack1);
      ia.req0      = 1'b0;
      ia.tx_finish = (i == fin);
      ia.err_clr   = (i == clr);
      @(negedge clk);
    end
    ia.tx_finish = 1'b0;
    ia.err_clr   = 1'b0;
  endtask

  task automatic serve(input logic [7:0] d, input logic id);
    int n = 0;
    while (!ia.tx_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rr_start", ia.tx_start, 1);
    check("rr_data", ia.tx_data, d);
    check("rr_ack0", ia.ack0, !id);
    check("rr_ack1", ia.ack1, id);
    check("rr_grant", ia.grant_id, id);
    @(negedge clk);
    ia.tx_finish = 1'b1;
    @(negedge clk);
    ia.tx_finish = 1'b0;
  endtask

  initial begin
    ia.req0 = 0; ia.req1 = 0; ia.data0 = 0; ia.data1 = 0;
    ia.tx_finish = 0; ia.err_clr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", ia.busy, 0);
    check("rst_start", ia.tx_start, 0);
    check("rst_acks", {ia.ack0, ia.ack1}, 0);
    check("rst_data", ia.tx_data, 0);
    check("rst_grant", ia.grant_id, 1);
    check("rst_err", ia.timeout_err, 0);
    // single requester, finish 20 cycles after tx_start
    frame(8'h41, 21, 0);
    check("one_busy", ba, 21);
    check("one_starts", sa, 1);
    check("one_ack0", k0, 1);
    check("one_ack1", k1, 0);
    check("one_hold", ia.tx_data, 8'h41);
    check("one_grant", ia.grant_id, 0);
    check("one_idle", ia.busy, 0);
    // both requesting: alternate starting with requester 0
    do_reset();
    ia.data0 = 8'h11; ia.data1 = 8'h22;
    ia.req0 = 1; ia.req1 = 1;
    serve(8'h11, 1'b0);
    serve(8'h22, 1'b1);
    serve(8'h11, 1'b0);
    ia.req0 = 0; ia.req1 = 0;
    repeat (3) @(negedge clk);
    check("rr_quiet", ia.busy, 0);
    // timeout after 16 WAIT cycles, sticky error
    do_reset();
    frame(8'h5a, 0, 0);
    check("to_busy", bb, 17);
    check("to_err", ib.timeout_err, 1);
    check("to_idle", ib.busy, 0);
    check("to_long_wait", ia.busy, 1);
    frame(8'h5a, 0, 17);
    check("to_clr_loses", ib.timeout_err, 1);
    check("to_busy2", bb, 17);
    ia.err_clr = 1;
    @(negedge clk);
    ia.err_clr = 0;
    check("to_clr", ib.timeout_err, 0);
    // finish on the 16th WAIT cycle beats the timeout
    do_reset();
    frame(8'h5a, 17, 0);
    check("edge_busy", bb, 17);
    check("edge_err", ib.timeout_err, 0);
    check("edge_idle", ib.busy, 0);
    // finish during START is ignored
    frame(8'h66, 1, 0);
    check("ign_busy", ba, 30);
    check("ign_wait", ia.busy, 1);
    check("ign_err_b", ib.timeout_err, 1);
    // async reset mid-WAIT, then req1 alone
    rst = 1'b1;
    #1;
    check("arst_busy", ia.busy, 0);
    check("arst_data", ia.tx_data, 0);
    check("arst_grant", ia.grant_id, 1);
    check("arst_err", ib.timeout_err, 0);
    check("arst_out", {ia.tx_start, ia.ack0, ia.ack1}, 0);
    @(negedge clk);
    rst = 1'b0;
    k1 = 0;
    for (int i = 0; i < 3; i++) begin
      k1 += int'(ia.ack0 | ia.ack1 | ia.tx_start);
      @(negedge clk);
    end
    check("arst_no_ack", k1, 0);
    ia.data1 = 8'h99;
    ia.req1  = 1;
    check("r1_pre", ia.ack1, 0);
    @(negedge clk);
    ia.req1 = 0;
    check("r1_start", ia.tx_start, 1);
    check("r1_ack1", ia.ack1, 1);
    check("r1_ack0", ia.ack0, 0);
    check("r1_data", ia.tx_data, 8'h99);
    check("r1_grant", ia.grant_id, 1);
    @(negedge clk);
    check("r1_pulse", ia.ack1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, maximum clk cycles spent in WAIT before abort; SHALL exceed the longest uart_tx frame.
REQ-002 clk  input  1  single block clock, shared with uart_tx.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0  input  1  requester 0 has a byte pending.
REQ-005 data0  input  8  requester 0 byte, stable while req0 high.
REQ-006 ack0  output  1  one-cycle pulse, requester 0 byte consumed.
REQ-007 req1  input  1  requester 1 has a byte pending.
REQ-008 data1  input  8  requester 1 byte, stable while req1 high.
REQ-009 ack1  output  1  one-cycle pulse, requester 1 byte consumed.
REQ-010 tx_start  output  1  one-cycle start pulse to uart_tx.
REQ-011 tx_data  output  8  byte to uart_tx.
REQ-012 tx_finish  input  1  one-cycle pulse from uart_tx at end of stop bit.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 grant_id  output  1  id of the requester most recently granted.
REQ-015 timeout_err  output  1  sticky, a frame timed out.
REQ-016 err_clr  input  1  synchronous clear of timeout_err.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT.
REQ-018 IDLE: at a clock edge with req0 or req1 high, select a winner, latch its data into tx_data, set grant_id, go to START; no request -> stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: if both requests are high, the requester not equal to grant_id wins; a single request always wins.
REQ-020 START lasts exactly one cycle: tx_start=1 and ack of the winner=1 in that cycle; next state WAIT.
REQ-021 Latency: request sampled at edge k -> tx_start/ack high in the cycle after edge k.
REQ-022 WAIT: tx_finish=1 -> IDLE; earliest next tx_start is the second cycle after the tx_finish cycle.
REQ-023 tx_data SHALL hold its value from START until the next START.
REQ-024 tx_finish outside WAIT SHALL be ignored.
REQ-025 WAIT counter counts cycles in WAIT; reaching TIMEOUT_CYCLES without tx_finish -> set timeout_err, go to IDLE.
REQ-026 tx_finish in the same cycle the counter reaches TIMEOUT_CYCLES: finish wins, no error.
REQ-027 err_clr=1 clears timeout_err; a timeout in the same cycle wins (flag stays set).
REQ-028 Requests dropped before being sampled in IDLE SHALL cause no ack and no transmission; acks are never issued outside START.
REQ-029 Counter width = $clog2(TIMEOUT_CYCLES+1); no wrap-around permitted.

Reset
REQ-030 rst asynchronously forces IDLE, ack0=ack1=0, tx_start=0, tx_data=0, busy=0, timeout_err=0, counter=0, grant_id=1 (requester 0 wins first contention).
REQ-031 Reset during START or WAIT SHALL drop the in-flight byte with no ack pulse after reset release.

Structure
REQ-032 State encoding and data width (8) SHALL reside in the shared package uart_pkg.
REQ-033 No sub-module: selection, FSM and counter are inline.

Verification
REQ-034 req0 only, data0=0x41, tx_finish 20 cycles after tx_start -> one tx_start, tx_data=0x41, ack0 pulse, ack1 never, busy high 21 cycles.
REQ-035 req0 and req1 held, data 0x11/0x22 -> tx_data sequence 0x11,0x22,0x11; ack0/ack1 alternate.
REQ-036 TIMEOUT_CYCLES=16, tx_finish never -> return to IDLE after 16 WAIT cycles, timeout_err=1 until err_clr pulse.
REQ-037 tx_finish coincident with the 16th WAIT cycle -> IDLE, timeout_err stays 0.
REQ-038 rst asserted mid-WAIT -> all outputs at reset values immediately; after release, re-asserted req1 alone is granted with correct ack1 timing.
